// File: rtl/receiver_to_value.sv
// receiver_to_value: measures the high time of four RC-receiver PWM pins in
// microseconds, rejects implausible pulses and scales 1000..2000 us linearly
// to -9000..9000 (18 counts per us around 1500 us).
// Outputs carry the low N_VAL bits of that two's complement value, so at
// N_VAL = 14 the value -9000 reads as 14'h1CD8.
// Optional failsafe timeout per channel: define RX_FAILSAFE_EN.

module rx_chan #(
  parameter int               N_VAL       = 14,
  parameter int               CLKS_PER_US = 38,
  parameter int               TIMEOUT_US  = 25000,
  parameter logic [N_VAL-1:0] RST_VAL     = '0
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             pwm_i,
  output logic [N_VAL-1:0] val_o,
  output logic             strobe_o,
  output logic             lost_o
);
  localparam int               SUB_W   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(CLKS_PER_US - 1);

  typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sync_q;
  logic [SUB_W-1:0]        sub_q, sub_d;
  logic [11:0]             width_q, width_d, width_inc;
  logic [11:0]             meas_q, meas_d;
  logic                    done_q, done_d;
  logic                    rise, fall, wrap, load, fire;
  logic [11:0]             clamped;
  logic signed [11:0]      dev;
  logic signed [N_VAL-1:0] dev_x, prod;
  logic [N_VAL-1:0]        val_q;
  logic                    strobe_q;

  // Two synchronizer flops plus edge history. Preset high so that a pin that
  // is already high when reset releases can never look like a rising edge.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) sync_q <= 3'b111;
    else     sync_q <= {sync_q[1:0], pwm_i};
  end

  assign rise      = sync_q[1] & ~sync_q[2];
  assign fall      = ~sync_q[1] & sync_q[2];
  assign wrap      = (sub_q == SUB_MAX);
  assign width_inc = (wrap && width_q != 12'hFFF) ? width_q + 12'd1 : width_q;

  // Measurement state and counters.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= SYNC;
      sub_q   <= '0;
      width_q <= '0;
      meas_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      width_q <= width_d;
      meas_q  <= meas_d;
      done_q  <= done_d;
    end
  end

  // Next state. The fall cycle is still counted as high time so the total
  // high cycles seen equals the pin's high cycles; width is floor(cycles/C).
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    width_d = width_q;
    meas_d  = meas_q;
    done_d  = 1'b0;
    case (state_q)
      SYNC: if (!sync_q[1]) state_d = LOW;
      LOW: begin
        if (rise) begin
          sub_d   = '0;
          width_d = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        sub_d   = wrap ? '0 : sub_q + 1'b1;
        width_d = width_inc;
        if (fall) begin
          meas_d  = width_inc;
          done_d  = 1'b1;
          state_d = LOW;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Scaling: clamp, centre on 1500 us, multiply by 18 as (d<<4)+(d<<1).
  assign clamped = (meas_q < 12'd1000) ? 12'd1000 :
                   (meas_q > 12'd2000) ? 12'd2000 : meas_q;
  assign dev     = signed'(clamped - 12'd1500);
  assign dev_x   = N_VAL'(dev);
  assign prod    = (dev_x <<< 4) + (dev_x <<< 1);
  assign load    = done_q && (meas_q >= 12'd900) && (meas_q <= 12'd2100);

`ifdef RX_FAILSAFE_EN
  localparam int TO_W = $clog2(TIMEOUT_US + 1);

  logic [SUB_W-1:0] tpre_q;
  logic [TO_W-1:0]  tcnt_q;
  logic             lost_q, tick;

  assign tick = (tpre_q == SUB_MAX);
  assign fire = tick && (tcnt_q == TO_W'(TIMEOUT_US - 1));

  // Microseconds since the last valid pulse; saturates once it has fired.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tpre_q <= '0;
      tcnt_q <= '0;
      lost_q <= 1'b0;
    end else if (load) begin
      tpre_q <= '0;
      tcnt_q <= '0;
      lost_q <= 1'b0;
    end else begin
      tpre_q <= tick ? '0 : tpre_q + 1'b1;
      if (tick && tcnt_q != TO_W'(TIMEOUT_US)) tcnt_q <= tcnt_q + 1'b1;
      if (fire) lost_q <= 1'b1;
    end
  end

  assign lost_o = lost_q;
`else
  localparam int unused_timeout_us = TIMEOUT_US;
  assign fire   = 1'b0;
  assign lost_o = 1'b0;
`endif

  // Output register: a valid pulse wins over a timeout in the same cycle.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      val_q    <= RST_VAL;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= load | fire;
      if (load)      val_q <= prod;
      else if (fire) val_q <= RST_VAL;
    end
  end

  assign val_o    = val_q;
  assign strobe_o = strobe_q;
endmodule

module receiver_to_value #(
  parameter int N_VAL       = 14,
  parameter int CLKS_PER_US = 38,
  parameter int TIMEOUT_US  = 25000
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             throttle_pwm,
  input  logic             yaw_pwm,
  input  logic             roll_pwm,
  input  logic             pitch_pwm,
  output logic [N_VAL-1:0] throttle_val,
  output logic [N_VAL-1:0] yaw_val,
  output logic [N_VAL-1:0] roll_val,
  output logic [N_VAL-1:0] pitch_val,
  output logic [3:0]       val_strobe,
  output logic [3:0]       rx_lost
);
  localparam logic signed [31:0] THR_RST_FULL = -32'sd9000;
  localparam logic [N_VAL-1:0]   THR_RST      = THR_RST_FULL[N_VAL-1:0];

  logic [3:0]            pwm;
  logic [3:0][N_VAL-1:0] val;

  assign pwm = {pitch_pwm, roll_pwm, yaw_pwm, throttle_pwm};

  // Four independent channels; throttle idles at full-low, the others centred.
  for (genvar g = 0; g < 4; g++) begin : g_ch
    rx_chan #(
      .N_VAL      (N_VAL),
      .CLKS_PER_US(CLKS_PER_US),
      .TIMEOUT_US (TIMEOUT_US),
      .RST_VAL    ((g == 0) ? THR_RST : {N_VAL{1'b0}})
    ) u_ch (
      .sys_clk (sys_clk),
      .rst     (rst),
      .pwm_i   (pwm[g]),
      .val_o   (val[g]),
      .strobe_o(val_strobe[g]),
      .lost_o  (rx_lost[g])
    );
  end

  assign throttle_val = val[0];
  assign yaw_val      = val[1];
  assign roll_val     = val[2];
  assign pitch_val    = val[3];
endmodule
